// File: rtl/seg7_pkg.sv
// Shared types, constants and glyph decode for the seg7 scan driver.
// Glyph patterns are active-low, bit0 = segment a.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index 0 is the rightmost entry: 0..9, A, b, C, d, E, F
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    return GLYPH_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble -> active-low segment pattern, with a blank override.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_OFF : glyph(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a tear-free shadow register.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
//
//   state | meaning
//   IDLE  | display dark, digit 0, counter cleared
//   SHOW  | one anode low, glyph of the current digit driven
//   GAP   | all off between digits (anti-ghosting)
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DWELL_TICKS = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int MAX_T = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int DW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] DWELL_LD   = CW'(DWELL_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LD   = (BLANK_TICKS > 0) ? CW'(BLANK_TICKS - 1) : '0;
  localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);

  scan_state_t state, state_n;
  logic [DW-1:0] digit, digit_n, digit_adv;
  logic [CW-1:0] cnt, cnt_n;
  logic          wrap;

  logic [4*NUM_DIGITS-1:0] disp_val, disp_val_n, shadow_val;
  logic [NUM_DIGITS-1:0]   disp_dp, disp_dp_n, shadow_dp;
  logic [3:0]              sel_nib;
  logic                    sel_dp;
  logic                    blank;
  logic [6:0]              seg_dec;

  assign digit_adv = (digit == LAST_DIGIT) ? '0 : digit + DW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      digit <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      digit <= digit_n;
      cnt   <= cnt_n;
    end
  end

  // Counters are down-counters loaded on state entry; terminal count is zero.
  always_comb begin
    state_n = state;
    digit_n = digit;
    cnt_n   = cnt;
    wrap    = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      digit_n = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = SHOW;
          digit_n = '0;
          cnt_n   = DWELL_LD;
        end
        SHOW: begin
          if (cnt != '0) begin
            cnt_n = cnt - CW'(1);
          end else if (BLANK_TICKS == 0) begin
            digit_n = digit_adv;
            cnt_n   = DWELL_LD;
            wrap    = (digit == LAST_DIGIT);
          end else begin
            state_n = GAP;
            cnt_n   = BLANK_LD;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt_n = cnt - CW'(1);
          end else begin
            state_n = SHOW;
            digit_n = digit_adv;
            cnt_n   = DWELL_LD;
            wrap    = (digit == LAST_DIGIT);
          end
        end
        default: begin
          state_n = IDLE;
          digit_n = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // A load landing on the commit edge bypasses the shadow.
  always_comb begin
    disp_val_n = disp_val;
    disp_dp_n  = disp_dp;
    if (wrap) begin
      if (load) begin
        disp_val_n = value_in;
        disp_dp_n  = dp_in;
      end else if (pending) begin
        disp_val_n = shadow_val;
        disp_dp_n  = shadow_dp;
      end
    end
  end

  assign sel_nib = disp_val_n[{digit_n, 2'b00} +: 4];
  assign sel_dp  = disp_dp_n[digit_n];

`ifdef LEADING_ZERO_BLANK_EN
  logic [DW-1:0] msd;

  always_comb begin
    msd = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (disp_val_n[4*k +: 4] != 4'h0) msd = DW'(k);
    end
  end

  assign blank = (digit_n > msd);
`else
  assign blank = 1'b0;
`endif

  seg7_decode u_decode (
    .nibble (sel_nib),
    .blank  (blank),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
      pending    <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else begin
      disp_val   <= disp_val_n;
      disp_dp    <= disp_dp_n;
      frame_done <= wrap;
      if (state_n == SHOW) begin
        an  <= ~(NUM_DIGITS'(1) << digit_n);
        seg <= seg_dec;
        dp  <= ~sel_dp;
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
      if (load) begin
        shadow_val <= value_in;
        shadow_dp  <= dp_in;
      end
      if (wrap)      pending <= 1'b0;
      else if (load) pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: default 4-digit instance plus a 1-digit, no-gap instance.
// Expectations for blanked digits follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp, frame_done, pending;

  logic        enable_b, load_b;
  logic [3:0]  value_b;
  logic [0:0]  dp_in_b;
  logic [0:0]  an_b;
  logic [6:0]  seg_b;
  logic        dp_b, fd_b, pend_b;

  int checks = 0;
  int errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  seg7_scan_driver #(.NUM_DIGITS(4), .DWELL_TICKS(4), .BLANK_TICKS(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .value_in(value_in), .dp_in(dp_in), .an(an), .seg(seg), .dp(dp),
    .frame_done(frame_done), .pending(pending)
  );

  seg7_scan_driver #(.NUM_DIGITS(1), .DWELL_TICKS(4), .BLANK_TICKS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .load(load_b),
    .value_in(value_b), .dp_in(dp_in_b), .an(an_b), .seg(seg_b), .dp(dp_b),
    .frame_done(fd_b), .pending(pend_b)
  );

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dpm;
    logic [3:0][6:0] segs;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < 60);
    if (frame_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: frame_done timeout after %0d cycles", name, n);
    end
  endtask

  // Called right after frame_done is observed; walks one full frame.
  task automatic check_frame(input vec_t v);
    logic [3:0] ea;
    logic       edp;
    for (int d = 0; d < 4; d++) begin
      ea  = ~(4'b0001 << d);
      edp = ~v.dpm[d];
      for (int t = 0; t < 4; t++) begin
        if (!(d == 0 && t == 0)) step();
        chk("frame_an", an, ea);
        if (t == 0) begin
          chk("frame_seg", seg, v.segs[d]);
          chk("frame_dp", dp, edp);
        end
      end
      step();
      chk("gap_an", an, 4'hF);
      chk("gap_seg", seg, 7'h7F);
    end
    step();
    chk("frame_done_period", frame_done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic efd;

    vecs[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'h89AB, 4'b0101, {7'h00, 7'h10, 7'h08, 7'h03}};
    vecs[2] = '{16'hCDEF, 4'b1000, {7'h46, 7'h21, 7'h06, 7'h0E}};
    vecs[3] = '{16'h5670, 4'b1111, {7'h12, 7'h02, 7'h78, 7'h40}};

    rst_n = 1'b0; enable = 1'b1; load = 1'b1; value_in = 16'hFFFF; dp_in = 4'hF;
    enable_b = 1'b1; load_b = 1'b1; value_b = 4'hF; dp_in_b = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_pending", pending, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
    end

    rst_n = 1'b1; load = 1'b0; enable = 1'b0; load_b = 1'b0; enable_b = 1'b0;
    dp_in = 4'h0;
    step();
    chk("idle_an", an, 4'hF);

    enable = 1'b1;
    step();
    chk("enable_first_an", an, 4'hE);
    chk("enable_first_seg", seg, 7'h40);
    chk("enable_first_dp", dp, 1'b1);
    n = 0;
    do begin step(); n++; end while (frame_done !== 1'b1 && n < 60);
    chk("first_frame_period", n, 20);
    chk("no_load_display", seg, 7'h40);
    chk("no_load_pending", pending, 1'b0);

    for (int i = 0; i < 4; i++) begin
      value_in = vecs[i].value; dp_in = vecs[i].dpm; load = 1'b1;
      step();
      load = 1'b0;
      chk("pending_after_load", pending, 1'b1);
      wait_fd("table_commit");
      chk("pending_after_commit", pending, 1'b0);
      check_frame(vecs[i]);
    end

    // Tear-free: two loads mid-frame, last one wins.
    dp_in = 4'h0;
    for (int k = 0; k < 6; k++) step();
    value_in = 16'hABCD; load = 1'b1;
    step();
    load = 1'b0;
    step();
    value_in = 16'h0042; load = 1'b1;
    step();
    load = 1'b0;
    chk("tear_pending", pending, 1'b1);
    bad = 0; n = 0;
    do begin
      step(); n++;
      if ((an == 4'hE && seg == 7'h21) || (an == 4'hD && seg == 7'h46)) bad++;
    end while (frame_done !== 1'b1 && n < 60);
    chk("tear_commit_seen", frame_done, 1'b1);
    chk("tear_pending_cleared", pending, 1'b0);
    chk("tear_d0_seg", seg, 7'h24);
    chk("tear_abcd_never_shown", bad, 0);
    for (int k = 0; k < 5; k++) step();
    chk("tear_d1_an", an, 4'hD);
    chk("tear_d1_seg", seg, 7'h19);
    for (int k = 0; k < 5; k++) step();
    chk("tear_d2_an", an, 4'hB);
    chk("tear_d2_seg", seg, LZ_SEG);

    // Load coincident with the commit edge overrides a pending shadow.
    wait_fd("coinc_align");
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 5) begin value_in = 16'h1111; load = 1'b1; end
      else load = 1'b0;
    end
    chk("coinc_pending_before", pending, 1'b1);
    value_in = 16'h9876; dp_in = 4'b0001; load = 1'b1;
    step();
    load = 1'b0;
    chk("coinc_frame_done", frame_done, 1'b1);
    chk("coinc_d0_seg", seg, 7'h02);
    chk("coinc_d0_dp", dp, 1'b0);
    chk("coinc_pending", pending, 1'b0);
    step();
    chk("coinc_pending_next", pending, 1'b0);
    for (int k = 0; k < 4; k++) step();
    chk("coinc_d1_an", an, 4'hD);
    chk("coinc_d1_seg", seg, 7'h78);
    chk("coinc_d1_dp", dp, 1'b1);

    // enable dropped during digit 2; shadow/pending survive.
    wait_fd("drop_align");
    for (int k = 0; k < 11; k++) step();
    chk("drop_d2_an", an, 4'hB);
    enable = 1'b0; value_in = 16'h4321; load = 1'b1;
    step();
    load = 1'b0;
    chk("drop_an_off", an, 4'hF);
    chk("drop_seg_off", seg, 7'h7F);
    chk("drop_dp_off", dp, 1'b1);
    chk("drop_pending_kept", pending, 1'b1);
    step();
    chk("drop_an_still_off", an, 4'hF);
    enable = 1'b1;
    step();
    chk("reen_an", an, 4'hE);
    chk("reen_old_seg", seg, 7'h02);
    for (int t = 1; t < 4; t++) begin
      step();
      chk("reen_dwell_an", an, 4'hE);
    end
    step();
    chk("reen_gap_an", an, 4'hF);
    n = 0;
    do begin step(); n++; end while (frame_done !== 1'b1 && n < 60);
    chk("reen_frame_period", n, 16);
    chk("reen_commit_seg", seg, 7'h79);
    chk("reen_pending", pending, 1'b0);

    // Leading zeros: 16'h0007.
    value_in = 16'h0007; dp_in = 4'b1000; load = 1'b1;
    step();
    load = 1'b0;
    wait_fd("lz_commit");
    chk("lz_d0_seg", seg, 7'h78);
    for (int d = 1; d < 4; d++) begin
      for (int k = 0; k < 5; k++) step();
      chk("lz_an", an, 32'(~(4'b0001 << d) & 4'hF));
      chk("lz_seg", seg, LZ_SEG);
    end
    chk("lz_d3_dp", dp, 1'b0);

    // Single digit, no gap.
    value_b = 4'h5; dp_in_b = 1'b0; load_b = 1'b1; enable_b = 1'b1;
    step();
    load_b = 1'b0;
    chk("b_first_an", an_b, 1'b0);
    n = 0;
    do begin step(); n++; end while (fd_b !== 1'b1 && n < 20);
    chk("b_first_fd", n, 4);
    chk("b_seg", seg_b, 7'h12);
    for (int i = 1; i <= 12; i++) begin
      step();
      efd = (i % 4 == 0);
      chk("b_an", an_b, 1'b0);
      chk("b_fd", fd_b, efd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
